// File: rtl/dequantize_loader.sv
// ============================================================================
// dequantize_loader : assembles packed SRAM beats into sign-extended
//                     accumulator-width rows for a systolic array.
// Rev 1.0
// ============================================================================
`default_nettype none

module dequantize_loader #(
    parameter int ARRAY_SIZE        = 8,
    parameter int SRAM_DATA_WIDTH   = 32,
    parameter int DATA_WIDTH        = 8,
    parameter int OUTPUT_DATA_WIDTH = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     clear,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [SRAM_DATA_WIDTH-1:0]               in_data,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [ARRAY_SIZE*(2*DATA_WIDTH+5)-1:0]   out_data,
    output logic [15:0]                              row_cnt
);

    localparam int ORI_WIDTH = 2*DATA_WIDTH + 5;
    localparam int LPB_RAW   = SRAM_DATA_WIDTH / OUTPUT_DATA_WIDTH;
    localparam int LPB       = (LPB_RAW > 0) ? LPB_RAW : 1;
    localparam int BEATS     = (ARRAY_SIZE / LPB > 0) ? ARRAY_SIZE / LPB : 1;
    localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ODW       = OUTPUT_DATA_WIDTH;

    localparam logic [BW-1:0] c_LAST_BEAT = BW'(BEATS - 1);

    generate
        if ((SRAM_DATA_WIDTH % OUTPUT_DATA_WIDTH) != 0 || LPB_RAW == 0 ||
            (ARRAY_SIZE % LPB) != 0) begin : g_cfg_check
            $error("dequantize_loader: SRAM word must hold a whole number of values and a row a whole number of beats");
        end
    endgenerate

    logic [BW-1:0]                     beat_q, beat_d;
    logic [ARRAY_SIZE*ODW-1:0]         asm_q, asm_d;
    logic [ARRAY_SIZE*ORI_WIDTH-1:0]   row_ext;
    logic [ARRAY_SIZE*ORI_WIDTH-1:0]   out_data_q, out_data_d;
    logic                              out_valid_q, out_valid_d;
    logic [15:0]                       row_cnt_q, row_cnt_d;

    logic last_beat;
    logic in_fire;
    logic out_fire;

    // Only the final beat can be blocked: it is the one that overwrites the held row.
    assign last_beat = (beat_q == c_LAST_BEAT);
    assign in_ready  = !last_beat || !out_valid_q || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    always_comb begin
        asm_d = asm_q;
        if (!clear && in_fire) begin
            for (int k = 0; k < LPB; k++) begin
                asm_d[(int'(beat_q)*LPB + k)*ODW +: ODW] = in_data[k*ODW +: ODW];
            end
        end
    end

    // Built from asm_d so the final beat lands in the row in its own cycle.
    generate
        for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
            if (ORI_WIDTH > ODW) begin : g_sext
                assign row_ext[i*ORI_WIDTH +: ORI_WIDTH] =
                    {{(ORI_WIDTH-ODW){asm_d[i*ODW + ODW - 1]}}, asm_d[i*ODW +: ODW]};
            end else begin : g_trunc
                assign row_ext[i*ORI_WIDTH +: ORI_WIDTH] = asm_d[i*ODW +: ORI_WIDTH];
            end
        end
    endgenerate

    always_comb begin
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        row_cnt_d   = row_cnt_q;
        if (clear) begin
            beat_d      = '0;
            out_valid_d = 1'b0;
            row_cnt_d   = '0;
        end else begin
            if (in_fire) begin
                beat_d = last_beat ? '0 : beat_q + BW'(1);
            end
            if (out_fire) begin
                row_cnt_d   = row_cnt_q + 16'd1;
                out_valid_d = 1'b0;
            end
            if (in_fire && last_beat) begin
                out_valid_d = 1'b1;
                out_data_d  = row_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            row_cnt_q   <= '0;
        end else begin
            beat_q      <= beat_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            row_cnt_q   <= row_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign row_cnt   = row_cnt_q;

endmodule

`default_nettype wire
